// File: rtl/nor_decoder_pkg.sv
// Shared types and decode helper for the synchronous NOR-style decoder.
// Terms are built at maximum width; callers keep the low 2**N_IN bits.
package nor_decoder_pkg;

  localparam int N_IN_MAX   = 6;
  localparam int N_TERM_MAX = 1 << N_IN_MAX;

  typedef enum logic {
    TRACK   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // pol=1 gives a one-hot minterm, pol=0 the one-cold maxterm; a masked term stays inactive.
  function automatic logic [N_TERM_MAX-1:0] decode_term(
    input logic [N_IN_MAX-1:0]   code,
    input logic [N_TERM_MAX-1:0] mask,
    input logic                  pol
  );
    logic [N_TERM_MAX-1:0] t;
    t       = '0;
    t[code] = mask[code];
    return pol ? t : ~t;
  endfunction

endpackage

// File: rtl/nor_decoder_sync_stable_filter.sv
// Input stability filter: tracks a candidate code and how long it has held.
// settled is registered (cnt==SETTLE); abandoned partial candidates bump a saturating glitch counter.
module stable_filter
  import nor_decoder_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int SETTLE   = 3,
  parameter int GLITCH_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_IN-1:0]     i_data,
  output logic [N_IN-1:0]     o_cand,
  output logic                o_settled,
  output logic [GLITCH_W-1:0] o_glitch_cnt
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  logic [N_IN-1:0]     r_cand;
  logic [CW-1:0]       r_cnt;
  logic [GLITCH_W-1:0] r_glitch;
  logic                w_settled;

  assign w_settled = (r_cnt == CW'(SETTLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_glitch <= '0;
    end else if (i_data != r_cand) begin
      r_cand <= i_data;
      r_cnt  <= CW'(1);
      // cnt==0 means no candidate yet (just out of reset), so nothing was abandoned.
      if ((r_cnt != '0) && !w_settled && (r_glitch != '1))
        r_glitch <= r_glitch + 1'b1;
    end else if (!w_settled) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cand       = r_cand;
  assign o_settled    = w_settled;
  assign o_glitch_cnt = r_glitch;

endmodule

// File: rtl/nor_decoder_sync.sv
// Parametrised N_IN-to-2**N_IN decoder with stability filter and valid/ready output.
// Settled new code appears SETTLE+1 edges after first sample; outputs hold until out_ready.
module nor_decoder_sync
  import nor_decoder_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int SETTLE   = 3,
  parameter int OUT_POL  = 0,
  parameter int GLITCH_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_IN-1:0]      in_data,
  input  logic [(1<<N_IN)-1:0] en_mask,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [N_IN-1:0]      out_code,
  output logic [(1<<N_IN)-1:0] out_term,
  output logic [GLITCH_W-1:0]  glitch_cnt
);

  localparam int                N_TERM   = 1 << N_IN;
  localparam logic              POL      = (OUT_POL != 0);
  localparam logic [N_TERM-1:0] INACTIVE = POL ? '0 : '1;

  logic [N_IN-1:0]       w_cand;
  logic                  w_settled;
  logic [N_TERM_MAX-1:0] w_dec_full;
  logic [N_TERM-1:0]     w_dec;
  logic                  w_unused_dec;
  logic                  w_emit;

  state_t                r_state;
  logic                  r_valid;
  logic [N_IN-1:0]       r_code;
  logic [N_TERM-1:0]     r_term;
  logic [N_IN-1:0]       r_last_code;
  logic                  r_last_valid;

  stable_filter #(
    .N_IN     (N_IN),
    .SETTLE   (SETTLE),
    .GLITCH_W (GLITCH_W)
  ) u_filter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (in_data),
    .o_cand       (w_cand),
    .o_settled    (w_settled),
    .o_glitch_cnt (glitch_cnt)
  );

  assign w_dec_full   = decode_term(N_IN_MAX'(w_cand), N_TERM_MAX'(en_mask), POL);
  assign w_dec        = w_dec_full[N_TERM-1:0];
  assign w_unused_dec = &{1'b0, w_dec_full};

  assign w_emit = w_settled && (!r_last_valid || (w_cand != r_last_code));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= TRACK;
      r_valid      <= 1'b0;
      r_code       <= '0;
      r_term       <= INACTIVE;
      r_last_code  <= '0;
      r_last_valid <= 1'b0;
    end else begin
      case (r_state)
        TRACK: begin
          if (w_emit) begin
            r_code       <= w_cand;
            r_term       <= w_dec;
            r_valid      <= 1'b1;
            r_last_code  <= w_cand;
            r_last_valid <= 1'b1;
            r_state      <= PRESENT;
          end
        end
        PRESENT: begin
          // en_mask is deliberately not re-sampled here: the presented term is frozen.
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= TRACK;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= TRACK;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_code  = r_code;
  assign out_term  = r_term;

endmodule

// File: tb/tb_nor_decoder_sync.sv
// Directed bench for nor_decoder_sync: N_IN=2, SETTLE=3, one instance per output polarity.
module tb_nor_decoder_sync;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] in_data = 2'b00;
  logic [3:0] en_mask = 4'b1111;
  logic       out_ready = 1'b0;

  logic       v0, v1;
  logic [1:0] c0, c1;
  logic [3:0] t0, t1;
  logic [7:0] g0, g1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nor_decoder_sync #(.N_IN(2), .SETTLE(3), .OUT_POL(0), .GLITCH_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .en_mask(en_mask), .out_ready(out_ready),
    .out_valid(v0), .out_code(c0), .out_term(t0), .glitch_cnt(g0)
  );

  nor_decoder_sync #(.N_IN(2), .SETTLE(3), .OUT_POL(1), .GLITCH_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .en_mask(en_mask), .out_ready(out_ready),
    .out_valid(v1), .out_code(c1), .out_term(t1), .glitch_cnt(g1)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_valid0"}, 64'(v0), 64'd0);
    check_val({tag, "_valid1"}, 64'(v1), 64'd0);
    check_val({tag, "_code0"},  64'(c0), 64'd0);
    check_val({tag, "_term0"},  64'(t0), 64'hF);
    check_val({tag, "_term1"},  64'(t1), 64'h0);
    check_val({tag, "_glitch0"}, 64'(g0), 64'd0);
  endtask

  // Reset is released on a falling edge so the next rising edge is "edge 1".
  task automatic apply_reset(input logic [1:0] d);
    rst_n   = 1'b0;
    in_data = d;
    #2;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Settle from first edge, emission on the 4th edge, then held without ready.
    apply_reset(2'b10);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_val("t2_pre_valid", 64'(v0), 64'd0);
    end
    tick();
    check_val("t2_valid", 64'(v0), 64'd1);
    check_val("t2_code",  64'(c0), 64'd2);
    check_val("t2_term",  64'(t0), 64'hB);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("t2_hold_valid", 64'(v0), 64'd1);
      check_val("t2_hold_code",  64'(c0), 64'd2);
      check_val("t2_hold_term",  64'(t0), 64'hB);
    end

    // Short-lived 01 is dropped as a glitch; 11 is presented and acked at once.
    out_ready = 1'b1;
    apply_reset(2'b01);
    tick();
    check_val("t3_e1_valid", 64'(v0), 64'd0);
    tick();
    check_val("t3_e2_valid", 64'(v0), 64'd0);
    in_data = 2'b11;
    for (int e = 3; e <= 5; e++) begin
      tick();
      check_val("t3_pre_valid", 64'(v0), 64'd0);
    end
    tick();
    check_val("t3_valid",  64'(v0), 64'd1);
    check_val("t3_code",   64'(c0), 64'd3);
    check_val("t3_term",   64'(t0), 64'h7);
    check_val("t3_glitch", 64'(g0), 64'd1);
    tick();
    check_val("t3_acked", 64'(v0), 64'd0);

    // A repeated stable code is not re-emitted; a new one is.
    out_ready = 1'b0;
    apply_reset(2'b10);
    repeat (4) tick();
    check_val("t4_valid", 64'(v0), 64'd1);
    out_ready = 1'b1;
    tick();
    check_val("t4_ack", 64'(v0), 64'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("t4_no_reemit", 64'(v0), 64'd0);
    end
    in_data = 2'b00;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_val("t4_pre_valid", 64'(v0), 64'd0);
    end
    tick();
    check_val("t4_new_valid", 64'(v0), 64'd1);
    check_val("t4_new_code",  64'(c0), 64'd0);
    check_val("t4_new_term",  64'(t0), 64'hE);

    // Mask is sampled at load only.
    out_ready = 1'b0;
    en_mask   = 4'b1011;
    apply_reset(2'b10);
    repeat (4) tick();
    check_val("t5_valid", 64'(v0), 64'd1);
    check_val("t5_code",  64'(c0), 64'd2);
    check_val("t5_term0", 64'(t0), 64'hF);
    check_val("t5_term1", 64'(t1), 64'h0);
    en_mask = 4'b0100;
    tick();
    check_val("t5_hold_term0", 64'(t0), 64'hF);
    check_val("t5_hold_term1", 64'(t1), 64'h0);
    check_val("t5_hold_valid", 64'(v0), 64'd1);

    // Reset mid-PRESENT, then re-emission of the still-stable input.
    en_mask = 4'b1111;
    apply_reset(2'b01);
    repeat (4) tick();
    check_val("t6_valid0", 64'(v0), 64'd1);
    check_val("t6_term0",  64'(t0), 64'hD);
    check_val("t6_term1",  64'(t1), 64'h2);
    rst_n = 1'b0;
    #1;
    check_reset("t6_midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_val("t6_pre_valid", 64'(v0), 64'd0);
    end
    tick();
    check_val("t6_re_valid0", 64'(v0), 64'd1);
    check_val("t6_re_valid1", 64'(v1), 64'd1);
    check_val("t6_re_code",   64'(c1), 64'd1);
    check_val("t6_re_term0",  64'(t0), 64'hD);
    check_val("t6_re_term1",  64'(t1), 64'h2);
    check_val("t6_glitch0",   64'(g0), 64'd0);
    check_val("t6_glitch1",   64'(g1), 64'd0);

    // Input change on the handshake cycle: ack completes and the filter restarts.
    out_ready = 1'b1;
    in_data   = 2'b10;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_val("t7_pre_valid", 64'(v0), 64'd0);
    end
    tick();
    check_val("t7_valid",  64'(v0), 64'd1);
    check_val("t7_code",   64'(c0), 64'd2);
    check_val("t7_term1",  64'(t1), 64'h4);
    check_val("t7_glitch", 64'(g0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
